frame_triple_buff: RTL and testbench
====================================

# frame_triple_buff

Parametrised single-clock on-chip frame store for the D8M capture-to-HDMI path, successor to the dual-counter frame RAM. Three frame banks are managed as a triple buffer: the camera-side writer always owns one bank, the display-side reader owns another, and the third holds the newest complete frame. The reader never sees a torn frame. Frames are repeated when the camera is slow and dropped when it is fast, and both events are counted for debug.

## Interface
- DATA_W, 10, pixel width in bits
- FRAME_PIX, 76800, pixels per frame (bank depth); ADDR_W = $clog2(FRAME_PIX+1)
- CNT_W, 16, width of the drop/repeat counters
- CLOCK  in  1  single clock for both ports
- RESET  in  1  synchronous, active-high reset
- W_CLR  in  1  write frame start: writer address returns to 0
- W_DE  in  1  write enable, one pixel per cycle
- W_DATA  in  DATA_W  pixel to write
- W_DONE  out  1  one-cycle pulse: the last pixel of a frame was written
- R_CLR  in  1  read frame start: bank swap point, reader address returns to 0
- R_DE  in  1  read request, one pixel per cycle
- R_DATA  out  DATA_W  read pixel
- R_VALID  out  1  R_DATA valid this cycle
- FRAME_RDY  out  1  at least one complete frame has been written since reset (sticky)
- DROP_CNT  out  CNT_W  completed frames overwritten before being read; saturates
- REPEAT_CNT  out  CNT_W  R_CLR events with no new frame while FRAME_RDY=1; saturates

## Operation
- Bank state: wr_bank, rd_bank, rdy_bank (2 bits each), rdy_valid.
  - Invariant: wr_bank != rd_bank.
  - When rdy_valid=1, rdy_bank is the third bank.
  - free_bank = 3 - wr_bank - rd_bank.
- Reset values: wr_bank=0, rd_bank=1, rdy_valid=0, both addresses 0. All outputs 0.
- Writer:
  - W_DE with wr_addr<FRAME_PIX writes W_DATA to {wr_bank, wr_addr}, then wr_addr+1.
  - Write at wr_addr=FRAME_PIX-1 completes the frame:
    - W_DONE=1 next cycle; FRAME_RDY set.
    - If rdy_valid was 1: DROP_CNT+1, and the writer takes the old rdy_bank.
    - Otherwise the writer takes free_bank.
    - rdy_bank<=wr_bank, rdy_valid<=1.
  - After completion, wr_addr=FRAME_PIX (done). Further W_DE is ignored until W_CLR.
  - W_CLR: wr_addr<=0 and the partial frame is discarded. The writer keeps its bank and rdy_valid is unchanged.
  - W_CLR and W_DE in the same cycle: the pixel is written at address 0 and wr_addr<=1.
- Reader:
  - R_CLR with rdy_valid=1: rd_bank<=rdy_bank, rdy_valid<=0. The old rd_bank becomes free.
  - R_CLR with rdy_valid=0: rd_bank is kept (frame repeat). REPEAT_CNT+1 only if FRAME_RDY=1.
  - R_CLR always sets rd_addr<=0.
  - R_DE with rd_addr<FRAME_PIX and FRAME_RDY=1 reads {rd_bank, rd_addr}, then rd_addr+1.
  - R_DE with rd_addr=FRAME_PIX, or with FRAME_RDY=0: R_VALID=0, R_DATA=0, no address change.
  - R_CLR and R_DE in the same cycle: the read uses the post-swap bank at address 0, and rd_addr<=1.
- Simultaneous frame completion and R_CLR:
  - Completion is resolved first, so the reader takes the just-completed bank.
  - The writer takes the old rdy_bank if rdy_valid was 1, else the old rd_bank.
  - DROP_CNT rules are unchanged.
- Counters saturate at all-ones.
- RESET mid-frame:
  - Returns to the reset state. FRAME_RDY clears and RAM contents are don't-care.
  - No read returns valid data until a new full frame completes.

## Timing
- Write: data lands in RAM at the W_DE edge. W_DONE asserts the cycle after the last pixel's edge.
- Read latency is exactly 1 cycle: R_DE at edge n gives R_DATA/R_VALID after edge n+1. R_DATA holds its value while R_VALID=0.
- Bank swaps take effect at the clock edge of R_CLR / completion.
- Throughput: one write and one read per cycle, sustained. Reads and writes never address the same bank, so there is no read-during-write hazard.

## Structure
- Package frame_buff_pkg:
  - NUM_BANKS=3
  - bank_t (2-bit) type
  - function free_bank(a,b) returning 3-a-b
- Sub-module frm_addr_counter (parametrised ADDR_W, LIMIT), instanced once per port: CLR/DE inputs, saturating at LIMIT, done flag.
- RAM: inferred simple-dual-port array inline, NUM_BANKS*FRAME_PIX words of DATA_W, registered read.
- Top level holds the bank state machine and counters.

## Test plan
Use FRAME_PIX=16, DATA_W=10.
- Ready/read: reset; write frame of values 0..15; R_CLR then 16 R_DE.
  - W_DONE one pulse; FRAME_RDY=1.
  - R_DATA 0..15 with R_VALID, 1-cycle latency.
  - 17th R_DE gives R_VALID=0.
- Drop: write frames A(100+i), B(200+i), C(300+i) with no R_CLR; then R_CLR and read.
  - DROP_CNT=2.
  - Reader sees C only.
- Repeat: after reading A, issue R_CLR twice with no new frame.
  - REPEAT_CNT=2.
  - A is re-read intact each time.
- Tear-free: reader streams frame A while the writer writes B fully and starts C.
  - Every value read is 100+i.
  - Next R_CLR yields B.
- Aborted frame: write 8 pixels, W_CLR, write full frame D(400+i); R_CLR and read.
  - Reader sees D.
  - Exactly one W_DONE; DROP_CNT unchanged.
- Collision and reset: R_CLR in the same cycle as the 16th write of E.
  - Reader gets E from address 0.
  - Then assert RESET mid-read: R_VALID=0, FRAME_RDY=0, both counters 0.

Source files
------------

// File: rtl/frame_buff_pkg.sv
// Shared types and helpers for the triple-buffered frame store.
package frame_buff_pkg;

  localparam int NUM_BANKS = 3;

  typedef logic [1:0] bank_t;

  // With banks numbered 0..2, the bank owned by neither a nor b is 3-a-b.
  function automatic bank_t free_bank(input bank_t a, input bank_t b);
    return bank_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/frm_addr_counter.sv
// Per-port pixel address counter: clear to 0, advance on enable, stop at LIMIT.
// The address output is the one used this cycle (0 while clr is asserted).
module frm_addr_counter #(
  parameter int ADDR_W = 17,
  parameter int LIMIT  = 76800
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              de,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic              step;

  assign done = (addr_reg == ADDR_W'(LIMIT));
  assign step = de & ~done;
  assign addr = clr ? '0 : addr_reg;

  // Clear wins; a clear with an access consumes address 0 and moves to 1.
  always_comb begin
    addr_next = addr_reg;
    if (clr) begin
      addr_next = de ? ADDR_W'(1) : '0;
    end else if (step) begin
      addr_next = addr_reg + ADDR_W'(1);
    end
  end

  // Address register.
  always_ff @(posedge clk) begin
    if (srst) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= addr_next;
    end
  end

endmodule

// File: rtl/frame_triple_buff.sv
// Triple-buffered single-clock frame store: writer, reader and "newest
// complete frame" each own one bank, so the reader never sees a torn frame.
module frame_triple_buff
  import frame_buff_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int FRAME_PIX = 76800,
  parameter int CNT_W     = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              W_CLR,
  input  logic              W_DE,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_DONE,
  input  logic              R_CLR,
  input  logic              R_DE,
  output logic [DATA_W-1:0] R_DATA,
  output logic              R_VALID,
  output logic              FRAME_RDY,
  output logic [CNT_W-1:0]  DROP_CNT,
  output logic [CNT_W-1:0]  REPEAT_CNT
);

  localparam int ADDR_W    = $clog2(FRAME_PIX + 1);
  localparam int MEM_DEPTH = NUM_BANKS * FRAME_PIX;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_done_flag;
  logic              r_done_flag;
  logic              r_de_gated;
  logic              w_fire;
  logic              r_fire;
  logic              frame_complete;

  bank_t wr_bank_reg, wr_bank_next;
  bank_t rd_bank_reg, rd_bank_next;
  bank_t rdy_bank_reg, rdy_bank_next;
  logic  rdy_valid_reg, rdy_valid_next;

  logic              frame_rdy_reg;
  logic              w_done_reg;
  logic              r_valid_reg;
  logic [DATA_W-1:0] r_data_reg;
  logic              drop_inc;
  logic              repeat_inc;
  logic [1:0]        cnt_inc;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  frm_addr_counter #(.ADDR_W(ADDR_W), .LIMIT(FRAME_PIX)) u_wr_cnt (
    .clk  (CLOCK),
    .srst (RESET),
    .clr  (W_CLR),
    .de   (W_DE),
    .addr (w_addr),
    .done (w_done_flag)
  );

  // Reads are refused outright until a first frame exists.
  assign r_de_gated = R_DE & frame_rdy_reg;

  frm_addr_counter #(.ADDR_W(ADDR_W), .LIMIT(FRAME_PIX)) u_rd_cnt (
    .clk  (CLOCK),
    .srst (RESET),
    .clr  (R_CLR),
    .de   (r_de_gated),
    .addr (r_addr),
    .done (r_done_flag)
  );

  assign w_fire         = W_DE & (W_CLR | ~w_done_flag);
  assign r_fire         = r_de_gated & (R_CLR | ~r_done_flag);
  assign frame_complete = w_fire & (w_addr == LAST_ADDR);

  // Bank ownership register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_bank_reg   <= 2'd0;
      rd_bank_reg   <= 2'd1;
      rdy_bank_reg  <= 2'd2;
      rdy_valid_reg <= 1'b0;
    end else begin
      wr_bank_reg   <= wr_bank_next;
      rd_bank_reg   <= rd_bank_next;
      rdy_bank_reg  <= rdy_bank_next;
      rdy_valid_reg <= rdy_valid_next;
    end
  end

  // Bank hand-over: a completing frame is resolved before a reader swap.
  always_comb begin
    wr_bank_next   = wr_bank_reg;
    rd_bank_next   = rd_bank_reg;
    rdy_bank_next  = rdy_bank_reg;
    rdy_valid_next = rdy_valid_reg;
    if (frame_complete && R_CLR) begin
      rd_bank_next   = wr_bank_reg;
      wr_bank_next   = rdy_valid_reg ? rdy_bank_reg : rd_bank_reg;
      rdy_valid_next = 1'b0;
    end else if (frame_complete) begin
      wr_bank_next   = rdy_valid_reg ? rdy_bank_reg : free_bank(wr_bank_reg, rd_bank_reg);
      rdy_bank_next  = wr_bank_reg;
      rdy_valid_next = 1'b1;
    end else if (R_CLR && rdy_valid_reg) begin
      rd_bank_next   = rdy_bank_reg;
      rdy_valid_next = 1'b0;
    end
  end

  // Derived strobes and RAM addresses; a read in a swap cycle uses the new bank.
  always_comb begin
    drop_inc   = frame_complete & rdy_valid_reg;
    repeat_inc = R_CLR & ~frame_complete & ~rdy_valid_reg & frame_rdy_reg;
    wr_idx     = MEM_AW'(wr_bank_reg) * MEM_AW'(FRAME_PIX) + MEM_AW'(w_addr);
    rd_idx     = MEM_AW'(rd_bank_next) * MEM_AW'(FRAME_PIX) + MEM_AW'(r_addr);
  end

  // Sticky frame-ready flag and one-cycle completion pulse.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      frame_rdy_reg <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      w_done_reg <= frame_complete;
      if (frame_complete) begin
        frame_rdy_reg <= 1'b1;
      end
    end
  end

  // RAM write port.
  always_ff @(posedge CLOCK) begin
    if (w_fire) begin
      mem[wr_idx] <= W_DATA;
    end
  end

  // RAM registered read: refused requests return 0, idle cycles hold data.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
    end else begin
      r_valid_reg <= r_fire;
      if (r_fire) begin
        r_data_reg <= mem[rd_idx];
      end else if (R_DE) begin
        r_data_reg <= '0;
      end
    end
  end

  assign cnt_inc = {repeat_inc, drop_inc};

  // Saturating debug counters: index 0 drops, index 1 repeats.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign W_DONE     = w_done_reg;
  assign FRAME_RDY  = frame_rdy_reg;
  assign R_VALID    = r_valid_reg;
  assign R_DATA     = r_data_reg;
  assign DROP_CNT   = g_cnt[0].cnt_reg;
  assign REPEAT_CNT = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_frame_triple_buff.sv
// Scoreboard bench for frame_triple_buff: frame-content reference model,
// read expectations queued at issue time and popped by a monitor.
module tb_frame_triple_buff;

  localparam int DW = 10;
  localparam int FP = 16;
  localparam int CW = 16;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          W_CLR = 1'b0;
  logic          W_DE = 1'b0;
  logic [DW-1:0] W_DATA = '0;
  logic          W_DONE;
  logic          R_CLR = 1'b0;
  logic          R_DE = 1'b0;
  logic [DW-1:0] R_DATA;
  logic          R_VALID;
  logic          FRAME_RDY;
  logic [CW-1:0] DROP_CNT;
  logic [CW-1:0] REPEAT_CNT;

  frame_triple_buff #(.DATA_W(DW), .FRAME_PIX(FP), .CNT_W(CW)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .W_CLR      (W_CLR),
    .W_DE       (W_DE),
    .W_DATA     (W_DATA),
    .W_DONE     (W_DONE),
    .R_CLR      (R_CLR),
    .R_DE       (R_DE),
    .R_DATA     (R_DATA),
    .R_VALID    (R_VALID),
    .FRAME_RDY  (FRAME_RDY),
    .DROP_CNT   (DROP_CNT),
    .REPEAT_CNT (REPEAT_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done_seen = 0;
  int exp_q[$];

  // Reference model: whole-frame contents, no bank bookkeeping.
  int m_wbuf[FP];
  int m_rdy[FP];
  int m_rd[FP];
  int m_wpos, m_rpos, m_drop, m_rep;
  bit m_rdy_v, m_frdy, m_rd_known, m_wdone;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wpos = 0; m_rpos = 0; m_drop = 0; m_rep = 0;
    m_rdy_v = 0; m_frdy = 0; m_rd_known = 0; m_wdone = 0;
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One clock cycle: drive inputs, advance the model, check status after the edge.
  task automatic cyc(input bit wclr, input bit wde, input int wd,
                     input bit rclr, input bit rde, input bit rst);
    bit completed;
    bit refused;
    logic [33:0] exp_status;
    W_CLR = wclr; W_DE = wde; W_DATA = wd[DW-1:0];
    R_CLR = rclr; R_DE = rde; RESET = rst;
    completed = 0;
    refused   = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (wclr) m_wpos = 0;
      if (wde && m_wpos < FP) begin
        m_wbuf[m_wpos] = wd & 32'h3ff;
        m_wpos++;
        completed = (m_wpos == FP);
      end
      if (rclr) begin
        if (completed) begin
          m_rd = m_wbuf; m_rd_known = 1;
          if (m_rdy_v) m_drop = sat(m_drop + 1);
          m_rdy_v = 0;
        end else if (m_rdy_v) begin
          m_rd = m_rdy; m_rd_known = 1; m_rdy_v = 0;
        end else if (m_frdy) begin
          m_rep = sat(m_rep + 1);
        end
        m_rpos = 0;
      end else if (completed) begin
        if (m_rdy_v) m_drop = sat(m_drop + 1);
        m_rdy = m_wbuf; m_rdy_v = 1;
      end
      if (rde) begin
        if (m_frdy && m_rpos < FP) begin
          exp_q.push_back(m_rd_known ? m_rd[m_rpos] : -1);
          m_rpos++;
        end else begin
          refused = 1;
        end
      end
      if (completed) m_frdy = 1;
    end
    m_wdone = completed;
    @(posedge CLOCK);
    #1;
    exp_status = {m_wdone, m_frdy, m_drop[CW-1:0], m_rep[CW-1:0]};
    chk("status{wdone,frdy,drop,rep}", {W_DONE, FRAME_RDY, DROP_CNT, REPEAT_CNT}, exp_status);
    if (refused) begin
      chk("refused_rvalid", R_VALID, 0);
      chk("refused_rdata", R_DATA, 0);
    end
    if (W_DONE) n_done_seen++;
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < FP; i++) cyc(i == 0, 1, base + i, 0, 0, 0);
  endtask

  task automatic read_frame(input bit with_clr);
    for (int i = 0; i < FP; i++) cyc(0, 0, 0, with_clr && i == 0, 1, 0);
  endtask

  task automatic drain(input string name);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every valid read pops the oldest expectation.
  always @(negedge CLOCK) begin
    if (R_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e >= 0) chk("rd_data", R_DATA, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset_rvalid", R_VALID, 0);
    chk("reset_rdata", R_DATA, 0);
    chk("reset_frame_rdy", FRAME_RDY, 0);

    // Read before any frame is refused.
    cyc(0, 0, 0, 0, 1, 0);

    // First frame 0..15, swap, read 16 pixels plus one past the end.
    d0 = n_done_seen;
    write_frame(0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ready_wdone_pulses", n_done_seen - d0, 1);
    chk("ready_frame_rdy", FRAME_RDY, 1);
    cyc(0, 0, 0, 1, 0, 0);
    read_frame(0);
    cyc(0, 0, 0, 0, 1, 0);
    drain("ready_pending");

    // Three frames with no swap: two drops, reader gets C.
    write_frame(100);
    write_frame(200);
    write_frame(300);
    chk("drop_cnt", DROP_CNT, 2);
    read_frame(1);
    drain("drop_pending");

    // Repeat: A read, then two swaps with no new frame.
    write_frame(100);
    read_frame(1);
    read_frame(1);
    read_frame(1);
    chk("repeat_cnt", REPEAT_CNT, 2);
    drain("repeat_pending");

    // Tear-free: stream A while B is written fully and C started.
    for (int i = 0; i < FP + 5; i++)
      cyc(i == 0 || i == FP, 1, (i < FP) ? 200 + i : 300 + i - FP, i == 0, i < FP, 0);
    read_frame(1);
    drain("tear_pending");

    // Aborted frame then D, starting D with clear and write together.
    d0 = n_done_seen;
    for (int i = 0; i < 8; i++) cyc(i == 0, 1, 500 + i, 0, 0, 0);
    write_frame(400);
    cyc(0, 0, 0, 0, 0, 0);
    chk("abort_wdone_pulses", n_done_seen - d0, 1);
    chk("abort_drop_cnt", DROP_CNT, 2);
    read_frame(1);
    drain("abort_pending");

    // Completion of E coincides with swap and read of address 0.
    for (int i = 0; i < FP - 1; i++) cyc(i == 0, 1, 600 + i, 0, 0, 0);
    cyc(0, 1, 600 + FP - 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("rst_rvalid", R_VALID, 0);
    chk("rst_frame_rdy", FRAME_RDY, 0);
    chk("rst_drop_cnt", DROP_CNT, 0);
    chk("rst_repeat_cnt", REPEAT_CNT, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    drain("reset_pending");

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
          $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 799) == 0);
    drain("random_pending");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
